// File: rtl/orb_bank_ctrl_pkg.sv
// rtl/orb_bank_ctrl_pkg.sv - shared sizes and state encoding for the ping-pong group-buffer path
package orb_bank_ctrl_pkg;

   localparam int WORD_BITS = 12;
   localparam int DEPTH     = 1024;
   localparam int LEVEL_W   = 15;
   localparam int LOW_WATER = 1;

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

   localparam int ADDR_W = addr_width(DEPTH);
   localparam int CNT_W  = $clog2(WORD_BITS);

   typedef enum logic [2:0] {
      IDLE,
      WAITB,
      SHIFT,
      WRITE,
      HOLD
   } orb_state_t;

endpackage

// File: rtl/orb_swap_detect.sv
// rtl/orb_swap_detect.sv - turns every toggle of the frame-former bank select into a swap pulse
module orb_swap_detect (
   input  logic clk,
   input  logic reset,
   input  logic sel,
   output logic swap
);

   logic sel_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sel_q <= 1'b0;
      else       sel_q <= sel;
   end

   assign swap = sel ^ sel_q;

endmodule

// File: rtl/orb_bank_ctrl.sv
// rtl/orb_bank_ctrl.sv - packs FIFO bits into 12-bit words and writes them into the free group-buffer bank
module orb_bank_ctrl
   import orb_bank_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bitData,
   input  logic [LEVEL_W-1:0]   bitLevel,
   input  logic                 orbSwitch,
   output logic                 bitRequest,
   output logic [WORD_BITS-1:0] orbWord,
   output logic [ADDR_W-1:0]    orbAddr,
   output logic                 orbWren,
   output logic                 bankFull,
   output logic                 starved,
   output logic [7:0]           shortCnt
);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_BITS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   orb_state_t           state;
   logic [WORD_BITS-2:0] shreg;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 swap;
   logic                 level_ok;
   logic [7:0]           short_next;

   orb_swap_detect u_swap (
      .clk   (clk),
      .reset (reset),
      .sel   (orbSwitch),
      .swap  (swap)
   );

   assign level_ok   = (bitLevel >= LEVEL_W'(LOW_WATER));
   assign short_next = (shortCnt == 8'hFF) ? shortCnt : shortCnt + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         bitRequest <= 1'b0;
         orbWord    <= '0;
         orbAddr    <= '0;
         orbWren    <= 1'b0;
         bankFull   <= 1'b0;
         starved    <= 1'b0;
         shortCnt   <= '0;
      end else begin
         bitRequest <= 1'b0;
         orbWren    <= 1'b0;
         starved    <= !level_ok && (state != HOLD);

         case (state)
            IDLE, WAITB, SHIFT: begin
               if (swap) begin
                  // Short bank: discard the partial word, including any bit in flight.
                  bit_cnt  <= '0;
                  orbAddr  <= '0;
                  shortCnt <= short_next;
                  state    <= IDLE;
               end else if (state == IDLE) begin
                  if (level_ok) begin
                     bitRequest <= 1'b1;
                     state      <= WAITB;
                  end
               end else if (state == WAITB) begin
                  state <= SHIFT;
               end else begin
                  shreg   <= {shreg[WORD_BITS-3:0], bitData};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     orbWord <= {shreg, bitData};
                     orbWren <= 1'b1;
                     state   <= WRITE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            WRITE: begin
               bit_cnt <= '0;
               state   <= IDLE;
               if (orbAddr == LAST_ADDR) begin
                  // A swap landing on the final write is an ordinary full-bank swap.
                  if (swap) begin
                     orbAddr <= '0;
                  end else begin
                     bankFull <= 1'b1;
                     state    <= HOLD;
                  end
               end else if (swap) begin
                  orbAddr  <= '0;
                  shortCnt <= short_next;
               end else begin
                  orbAddr <= orbAddr + 1'b1;
               end
            end

            HOLD: begin
               if (swap) begin
                  orbAddr  <= '0;
                  bankFull <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_orb_bank_ctrl.sv
// tb/tb_orb_bank_ctrl.sv - directed self-checking bench for orb_bank_ctrl
module tb_orb_bank_ctrl;

   localparam int SHORT_WORDS = 40;

   logic        clk;
   logic        reset;
   logic        bitData;
   logic [14:0] bitLevel;
   logic        orbSwitch;
   logic        bitRequest;
   logic [11:0] orbWord;
   logic [9:0]  orbAddr;
   logic        orbWren;
   logic        bankFull;
   logic        starved;
   logic [7:0]  shortCnt;

   orb_bank_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .bitData    (bitData),
      .bitLevel   (bitLevel),
      .orbSwitch  (orbSwitch),
      .bitRequest (bitRequest),
      .orbWord    (orbWord),
      .orbAddr    (orbAddr),
      .orbWren    (orbWren),
      .bankFull   (bankFull),
      .starved    (starved),
      .shortCnt   (shortCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          n_req   = 0;
   int          n_wren  = 0;
   logic [9:0]  last_addr = '0;
   logic [11:0] last_word = '0;
   bit          wren_seen = 0;
   logic [11:0] feed_word = '0;
   int          feed_pos  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of the FIFO model plus write monitor, sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      wren_seen = 0;
      if (bitRequest) begin
         n_req++;
         bitData  = feed_word[11 - feed_pos];
         feed_pos = (feed_pos == 11) ? 0 : feed_pos + 1;
      end
      if (orbWren) begin
         n_wren++;
         last_addr = orbAddr;
         last_word = orbWord;
         wren_seen = 1;
      end
   endtask

   task automatic wait_wren(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (wren_seen) ok = 1;
      end
   endtask

   initial begin
      bit ok;
      bit bf_seen;
      int r0, w0, t_first, t_next;

      reset     = 1'b1;
      bitData   = 1'b0;
      bitLevel  = '0;
      orbSwitch = 1'b0;
      repeat (3) tick();
      check("rst_req",   32'(bitRequest), 0);
      check("rst_wren",  32'(orbWren),    0);
      check("rst_full",  32'(bankFull),   0);
      check("rst_starv", 32'(starved),    0);
      check("rst_short", 32'(shortCnt),   0);
      check("rst_addr",  32'(orbAddr),    0);
      check("rst_word",  32'(orbWord),    0);
      reset = 1'b0;

      bf_seen = 0;
      repeat (50) begin
         tick();
         if (bankFull) bf_seen = 1;
      end
      check("empty_req",   32'(n_req),   0);
      check("empty_wren",  32'(n_wren),  0);
      check("empty_full",  32'(bf_seen), 0);
      check("empty_starv", 32'(starved), 1);

      // First word 1010_0101_1100: one write at address 0, 37 clk per word.
      feed_word = 12'hA5C;
      feed_pos  = 0;
      bitLevel  = 15'd100;
      r0 = n_req;
      w0 = n_wren;
      t_first = -1;
      for (int i = 0; i < 10 && t_first < 0; i++) begin
         tick();
         if (n_req == r0 + 1) t_first = cyc;
      end
      t_next = -1;
      for (int i = 0; i < 60 && t_next < 0; i++) begin
         tick();
         if (n_req == r0 + 13) t_next = cyc;
      end
      check("w1_period", 32'(t_next - t_first), 37);
      check("w1_count",  32'(n_wren - w0), 1);
      check("w1_word",   32'(last_word), 32'h0A5C);
      check("w1_addr",   32'(last_addr), 0);
      check("w1_next",   32'(orbAddr),   1);

      // Reset while shifting bit 7 of the second word.
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         if (n_req == r0 + 19) ok = 1;
      end
      check("rst7_reach", 32'(ok), 1);
      tick();
      reset = 1'b1;
      #1;
      check("rst7_req",   32'(bitRequest), 0);
      check("rst7_wren",  32'(orbWren),    0);
      check("rst7_addr",  32'(orbAddr),    0);
      check("rst7_word",  32'(orbWord),    0);
      check("rst7_full",  32'(bankFull),   0);
      check("rst7_short", 32'(shortCnt),   0);
      tick();
      reset     = 1'b0;
      feed_word = 12'h3C9;
      feed_pos  = 0;
      wait_wren(60, ok);
      check("post_rst_seen", 32'(ok), 1);
      check("post_rst_word", 32'(last_word), 32'h03C9);
      check("post_rst_addr", 32'(last_addr), 0);

      // Short bank: swap after SHORT_WORDS words plus 5 bits.
      feed_word = 12'h6B1;
      for (int i = 0; i < SHORT_WORDS + 5 && last_addr != 10'(SHORT_WORDS - 1); i++)
         wait_wren(60, ok);
      check("short_reach", 32'(last_addr), SHORT_WORDS - 1);
      r0 = n_req;
      for (int i = 0; i < 30 && n_req != r0 + 5; i++) tick();
      check("short_bits", 32'(n_req - r0), 5);
      tick();
      tick();
      orbSwitch = ~orbSwitch;
      tick();
      check("short_cnt",    32'(shortCnt),   1);
      check("short_addr",   32'(orbAddr),    0);
      check("short_no_req", 32'(bitRequest), 0);
      feed_word = 12'h2D7;
      feed_pos  = 0;
      w0 = n_wren;
      wait_wren(60, ok);
      check("short_seen", 32'(ok), 1);
      check("short_word", 32'(last_word), 32'h02D7);
      check("short_waddr", 32'(last_addr), 0);

      // Fill the bank to DEPTH words and hold.
      feed_word = 12'hE14;
      ok = 0;
      for (int i = 0; i < 40000 && !ok; i++) begin
         tick();
         if (bankFull) ok = 1;
      end
      check("full_seen", 32'(ok), 1);
      check("full_addr", 32'(last_addr), 1023);
      check("full_word", 32'(last_word), 32'h0E14);
      r0 = n_req;
      repeat (60) tick();
      check("hold_no_req", 32'(n_req - r0), 0);
      check("hold_full",   32'(bankFull),   1);
      orbSwitch = ~orbSwitch;
      tick();
      check("swap_full",  32'(bankFull), 0);
      check("swap_addr",  32'(orbAddr),  0);
      check("swap_short", 32'(shortCnt), 1);
      wait_wren(60, ok);
      check("swap_seen",  32'(ok), 1);
      check("swap_waddr", 32'(last_addr), 0);

      // Swap landing on the write to the last address.
      ok = 0;
      for (int i = 0; i < 40000 && !ok; i++) begin
         tick();
         if (wren_seen && last_addr == 10'd1023) ok = 1;
      end
      check("last_wr_seen", 32'(ok), 1);
      orbSwitch = ~orbSwitch;
      tick();
      check("last_full",  32'(bankFull), 0);
      check("last_addr0", 32'(orbAddr),  0);
      check("last_short", 32'(shortCnt), 1);
      wait_wren(60, ok);
      check("last_next_seen", 32'(ok), 1);
      check("last_next_addr", 32'(last_addr), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
